// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//
// Purpose:
//   Sequential unsigned 3-bit / 3-bit restoring divider. It produces one
//   quotient bit per BUSY cycle, MSB first. Operands are loaded through a
//   small command interface. The quotient and remainder sit in output
//   registers that change only when an operation completes or on reset.
//
// Ports (packed into two byte-wide buses):
//   io_in[0]    clk   rising-edge clock
//   io_in[1]    rst   synchronous, active-high reset
//   io_in[3:2]  cmd   00 idle, 01 load dividend, 10 load divisor, 11 start
//   io_in[6:4]  data  operand value for the load commands
//   io_in[7]    unused, ignored
//   io_out[2:0] quotient
//   io_out[5:3] remainder
//   io_out[6]   busy
//   io_out[7]   done
//
// Handshake: a start is accepted at any rising edge where the block is not
//   busy (IDLE or DONE). busy is high from the accepting edge through the
//   second following edge. At the third edge after acceptance, quotient and
//   remainder update and done rises. done then stays high until the next
//   accepted start or reset. Load commands are accepted in IDLE and DONE.
//   They are ignored while busy.
//
// Configuration macro:
//   DIVIDER_EARLY_ZERO_EN - when defined, a start with divisor = 0 skips
//   the iterations. The result (quotient 7, remainder = dividend) appears one
//   edge after the start, and busy never asserts. When the macro is
//   undefined, divide-by-zero runs the normal three-iteration sequence.
//   The restoring step itself produces the same values in that case.
//
// Debug/checker visibility: the FSM state is held in state_q, and the
// iteration count is held in iter_q.
// -----------------------------------------------------------------------------
module seq_restoring_divider (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] CMD_LD_DVD = 2'b01;
  localparam logic [1:0] CMD_LD_DVS = 2'b10;
  localparam logic [1:0] CMD_START  = 2'b11;

  // Unpack the input bus.
  logic       clk;
  logic       rst;
  logic [1:0] cmd;
  logic [2:0] data;
  logic       unused_in;

  assign clk       = io_in[0];
  assign rst       = io_in[1];
  assign cmd       = io_in[3:2];
  assign data      = io_in[6:4];
  assign unused_in = io_in[7];

  // Architectural state.
  state_e     state_q;
  logic [2:0] dvd_q;        // dividend operand register
  logic [2:0] dvs_q;        // divisor operand register
  logic [2:0] quo_q;        // visible quotient
  logic [2:0] rem_q;        // visible remainder
  logic       busy_q;
  logic       done_q;
  logic [1:0] iter_q;       // iteration counter, 0..2

  // Working copies used during an operation. They are kept apart from the
  // operand and result registers so that loads and outputs stay independent
  // of an operation in flight.
  logic [2:0] work_dvd_q;   // dividend, shifted left one bit per iteration
  logic [2:0] work_dvs_q;   // divisor captured at start
  logic [2:0] prem_q;       // partial remainder (always < 8 between steps)
  logic [1:0] work_quo_q;   // quotient bits gathered so far

`ifdef DIVIDER_EARLY_ZERO_EN
  // Set on the edge that accepts a divide-by-zero start. The result is
  // published on the following edge. The FSM stays in IDLE meanwhile, and
  // busy stays low.
  logic       zpend_q;
`endif

  // One restoring step.
  // The partial remainder is shifted left, and the next dividend bit enters
  // at the bottom. This needs 4 bits, because the shifted value can reach 13.
  // When the shifted value is at least the divisor, it is reduced. The
  // reduced value is smaller than the divisor, so 3 bits of the difference
  // are enough. When no reduction happens, the shifted value is already
  // smaller than the divisor and fits in 3 bits.
  // With divisor 0 the compare always succeeds, and nothing is subtracted.
  // The quotient therefore fills with ones, and the remainder ends up equal
  // to the dividend.
  logic [3:0] shift_d;
  logic       qbit_d;
  logic [2:0] prem_d;
  logic [2:0] quo_d;

  always_comb begin
    shift_d = {prem_q, work_dvd_q[2]};
    qbit_d  = (shift_d >= {1'b0, work_dvs_q});
    prem_d  = qbit_d ? (shift_d[2:0] - work_dvs_q) : shift_d[2:0];
    quo_d   = {work_quo_q, qbit_d};
  end

  // Control and datapath FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dvd_q      <= 3'd0;
      dvs_q      <= 3'd0;
      quo_q      <= 3'd0;
      rem_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_q     <= 2'd0;
      work_dvd_q <= 3'd0;
      work_dvs_q <= 3'd0;
      prem_q     <= 3'd0;
      work_quo_q <= 2'd0;
`ifdef DIVIDER_EARLY_ZERO_EN
      zpend_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
`ifdef DIVIDER_EARLY_ZERO_EN
          if (zpend_q) begin
            // Publish the divide-by-zero result. Commands are ignored on
            // this edge, as they would be while busy.
            zpend_q <= 1'b0;
            state_q <= S_DONE;
            quo_q   <= 3'd7;
            rem_q   <= work_dvd_q;
            done_q  <= 1'b1;
          end else begin
`endif
          case (cmd)
            CMD_LD_DVD: dvd_q <= data;
            CMD_LD_DVS: dvs_q <= data;
            CMD_START: begin
              // Capture the operand registers as they stand at this edge.
              work_dvd_q <= dvd_q;
              work_dvs_q <= dvs_q;
              prem_q     <= 3'd0;
              work_quo_q <= 2'd0;
              iter_q     <= 2'd0;
              done_q     <= 1'b0;
`ifdef DIVIDER_EARLY_ZERO_EN
              if (dvs_q == 3'd0) begin
                zpend_q <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_BUSY;
                busy_q  <= 1'b1;
              end
`else
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
`endif
            end
            default: ;
          endcase
`ifdef DIVIDER_EARLY_ZERO_EN
          end
`endif
        end

        S_BUSY: begin
          // All commands are ignored here. That includes start, so an
          // operation in flight cannot be restarted.
          prem_q     <= prem_d;
          work_quo_q <= quo_d[1:0];
          work_dvd_q <= {work_dvd_q[1:0], 1'b0};
          if (iter_q == 2'd2) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= quo_d;
            rem_q   <= prem_d;
            iter_q  <= 2'd0;
          end else begin
            iter_q <= iter_q + 2'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign io_out = {done_q, busy_q, rem_q, quo_q};

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//
// Self-checking bench for seq_restoring_divider.
//
// The reference model is cycle based. It tracks the operand registers and a
// countdown of edges until the next result. Results are computed with plain
// integer division and modulo. Every cycle, the model's expected io_out is
// pushed into exp_q and then compared with the DUT after the edge.
//
// The bench also contains:
//   - a vector table of divisions with constant expected outputs;
//   - hand-written multi-cycle sequences for reset, restart and load corners;
//   - a randomized command stream.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [2:0] data = 3'd0;
  logic       spare = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {spare, data, cmd, rst, clk};

  always #5 clk = ~clk;

  seq_restoring_divider dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h expected=0x%02h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0] m_dvd, m_dvs;      // operand registers
  logic [2:0] m_a, m_b;          // operands captured at start
  logic [2:0] m_q, m_r;
  logic       m_busy, m_done;
  int         m_cnt;             // edges left until the result appears

  logic [7:0] exp_q[$];

  task automatic model_edge(input logic r, input logic [1:0] c, input logic [2:0] d);
    if (r) begin
      m_dvd = 0; m_dvs = 0; m_a = 0; m_b = 0;
      m_q = 0; m_r = 0; m_busy = 0; m_done = 0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_q    = (m_b == 0) ? 3'd7 : 3'(m_a / m_b);
        m_r    = (m_b == 0) ? m_a  : 3'(m_a % m_b);
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      case (c)
        2'b01: m_dvd = d;
        2'b10: m_dvs = d;
        2'b11: begin
          m_a = m_dvd;
          m_b = m_dvs;
          m_done = 0;
`ifdef DIVIDER_EARLY_ZERO_EN
          if (m_dvs == 0) begin m_cnt = 1; m_busy = 0; end
          else begin m_cnt = 3; m_busy = 1; end
`else
          m_cnt = 3;
          m_busy = 1;
`endif
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle and checks io_out after the edge against the scoreboard.
  task automatic cyc(input logic r, input logic [1:0] c, input logic [2:0] d,
                     input logic sp, input string nm);
    logic [7:0] e;
    @(negedge clk);
    rst = r; cmd = c; data = d; spare = sp;
    model_edge(r, c, d);
    exp_q.push_back({m_done, m_busy, m_r, m_q});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(nm, io_out, e);
  endtask

  task automatic idle(input string nm);
    cyc(1'b0, 2'b00, 3'd0, 1'b0, nm);
  endtask

  task automatic load(input logic [2:0] a, input logic [2:0] b);
    cyc(1'b0, 2'b01, a, 1'b0, "load_dvd");
    cyc(1'b0, 2'b10, b, 1'b0, "load_dvs");
  endtask

  // Waits a bounded number of idle cycles for done. A timeout counts as a
  // failed comparison.
  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      if (io_out[7]) seen = 1;
      else idle(nm);
    end
    check({nm, "_done_seen"}, {7'd0, io_out[7]}, 8'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] dvd;
    logic [2:0] dvs;
    logic [7:0] exp_out;   // {done, busy, rem, quo}
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd6, 3'd2, 8'h83};
    vecs[1] = '{3'd7, 3'd3, 8'h8A};
    vecs[2] = '{3'd2, 3'd7, 8'h90};
    vecs[3] = '{3'd5, 3'd0, 8'hAF};
    vecs[4] = '{3'd7, 3'd1, 8'h87};
    vecs[5] = '{3'd0, 3'd5, 8'h80};
    vecs[6] = '{3'd7, 3'd7, 8'h81};
    vecs[7] = '{3'd1, 3'd2, 8'h88};
    vecs[8] = '{3'd7, 3'd0, 8'hBF};
    vecs[9] = '{3'd3, 3'd4, 8'h98};

    // Reset state.
    cyc(1'b1, 2'b00, 3'd0, 1'b0, "reset");
    cyc(1'b1, 2'b11, 3'd5, 1'b1, "reset_over_start");
    check("reset_io_out", io_out, 8'h00);
    idle("post_reset");

    // Table-driven divisions.
    for (int i = 0; i < 10; i++) begin
      load(vecs[i].dvd, vecs[i].dvs);
      cyc(1'b0, 2'b11, 3'd0, 1'b0, "start");
      wait_done("vec");
      check($sformatf("vec%0d_%0d/%0d", i, vecs[i].dvd, vecs[i].dvs), io_out, vecs[i].exp_out);
    end

    // Reset mid-operation aborts without a result.
    load(3'd6, 3'd2);
    cyc(1'b0, 2'b11, 3'd0, 1'b0, "abort_start");
    cyc(1'b1, 2'b00, 3'd0, 1'b0, "abort_rst");
    check("abort_all_zero", io_out, 8'h00);
    idle("abort_idle1");
    idle("abort_idle2");
    idle("abort_idle3");
    check("abort_no_done", {7'd0, io_out[7]}, 8'd0);

    // Loads and start are ignored while busy.
    load(3'd7, 3'd3);
    cyc(1'b0, 2'b11, 3'd0, 1'b0, "ign_start");
    cyc(1'b0, 2'b10, 3'd1, 1'b0, "ign_ld_dvs");
    cyc(1'b0, 2'b11, 3'd0, 1'b0, "ign_restart");
    idle("ign_n3");
    check("ign_result_7_3", io_out, 8'h8A);
    // A start in DONE clears done and divides 7 by 3 again.
    cyc(1'b0, 2'b11, 3'd0, 1'b0, "again_start");
    check("again_busy", io_out, 8'h4A);
    idle("again_n1");
    idle("again_n2");
    idle("again_n3");
    check("again_result", io_out, 8'h8A);

    // A load in DONE leaves done and the results untouched.
    cyc(1'b0, 2'b01, 3'd4, 1'b0, "done_load");
    check("done_load_hold", io_out, 8'h8A);
    cyc(1'b0, 2'b11, 3'd0, 1'b0, "done_start");
    check("done_start_clears", {7'd0, io_out[7]}, 8'd0);
    idle("d4_n1");
    idle("d4_n2");
    idle("d4_n3");
    check("result_4_3", io_out, 8'h89);

    // The last write to an operand register wins.
    cyc(1'b0, 2'b01, 3'd3, 1'b0, "lww_dvd_a");
    cyc(1'b0, 2'b01, 3'd6, 1'b0, "lww_dvd_b");
    cyc(1'b0, 2'b10, 3'd5, 1'b0, "lww_dvs_a");
    cyc(1'b0, 2'b10, 3'd2, 1'b0, "lww_dvs_b");
    cyc(1'b0, 2'b11, 3'd0, 1'b1, "lww_start");
    wait_done("lww");
    check("lww_result", io_out, 8'h83);

    // Randomized command stream with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
